// File: rtl/pipe_io_pkg.sv
// Shared constants for the memory-stage input-port conditioner.
package pipe_io_pkg;
    localparam int IN_W          = 5;
    localparam int DB_CYCLES_DEF = 50000;
    localparam int CNT_W         = 16;
endpackage

// File: rtl/inport_debounce.sv
// One switch bank: two-flop synchronizer, candidate/stability counter and
// debounced output with a single-cycle update pulse.
module inport_debounce
    import pipe_io_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEF
) (
    input  logic            i_clock,
    input  logic            i_reset,
    input  logic [IN_W-1:0] i_sw,
    output logic [IN_W-1:0] o_val,
    output logic            o_upd
);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

    logic [IN_W-1:0]  r_sync1, r_sync2, r_cand, r_out;
    logic [CNT_W-1:0] r_cnt;
    logic             w_upd;

    // Candidate has been seen for DB_CYCLES synchronized cycles and is new.
    assign w_upd = (r_cnt == CNT_MAX) && (r_cand != r_out);
    assign o_upd = w_upd;
    assign o_val = r_out;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_cand  <= '0;
            r_cnt   <= '0;
            r_out   <= '0;
        end else begin
            r_sync1 <= i_sw;
            r_sync2 <= r_sync1;
            if (r_sync2 != r_cand) begin
                r_cand <= r_sync2;
                r_cnt  <= '0;
            end else if (r_cnt != CNT_MAX) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_upd)
                r_out <= r_cand;
        end
    end
endmodule

// File: rtl/pipe_inport_cond.sv
// Debounced switch input ports with a sticky changed flag for the memory stage.
// Optional per-bank update counters cnt0/cnt1 under macro INPORT_EDGE_CNT_EN.
module pipe_inport_cond
    import pipe_io_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEF
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [IN_W-1:0] sw_port0,
    input  logic [IN_W-1:0] sw_port1,
    input  logic            ack,
    output logic [IN_W-1:0] in_port0,
    output logic [IN_W-1:0] in_port1,
    output logic            changed
`ifdef INPORT_EDGE_CNT_EN
    ,
    output logic [7:0]      cnt0,
    output logic [7:0]      cnt1
`endif
);
    logic w_upd0, w_upd1;
    logic r_changed;

    inport_debounce #(.DB_CYCLES(DB_CYCLES)) u_bank0 (
        .i_clock (clock),
        .i_reset (reset),
        .i_sw    (sw_port0),
        .o_val   (in_port0),
        .o_upd   (w_upd0)
    );

    inport_debounce #(.DB_CYCLES(DB_CYCLES)) u_bank1 (
        .i_clock (clock),
        .i_reset (reset),
        .i_sw    (sw_port1),
        .o_val   (in_port1),
        .o_upd   (w_upd1)
    );

    // A new value outranks a coincident ack so no change is ever lost.
    always_ff @(posedge clock) begin
        if (reset)
            r_changed <= 1'b0;
        else if (w_upd0 || w_upd1)
            r_changed <= 1'b1;
        else if (ack)
            r_changed <= 1'b0;
    end
    assign changed = r_changed;

`ifdef INPORT_EDGE_CNT_EN
    logic [7:0] r_cnt0, r_cnt1;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt0 <= '0;
            r_cnt1 <= '0;
        end else begin
            if (w_upd0) r_cnt0 <= r_cnt0 + 8'd1;
            if (w_upd1) r_cnt1 <= r_cnt1 + 8'd1;
        end
    end
    assign cnt0 = r_cnt0;
    assign cnt1 = r_cnt1;
`endif
endmodule

// File: tb/tb_pipe_inport_cond.sv
// Bench for pipe_inport_cond (DB_CYCLES=4) against a sample-window reference model.
module tb_pipe_inport_cond;
    localparam int DB = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       ack = 1'b0;
    logic [4:0] sw_port0 = 5'd0, sw_port1 = 5'd0;
    logic [4:0] in_port0, in_port1;
    logic       changed;
`ifdef INPORT_EDGE_CNT_EN
    logic [7:0] cnt0, cnt1;
`endif

    int n_cmp = 0, n_err = 0;
    int edge_n = 0, lastrst = 0;
    logic [4:0] hist0 [64];
    logic [4:0] hist1 [64];
    logic [4:0] m_out0 = 5'd0, m_out1 = 5'd0;
    logic       m_chg = 1'b0;
    logic [7:0] m_cnt0 = 8'd0, m_cnt1 = 8'd0;

    pipe_inport_cond #(.DB_CYCLES(DB)) dut (
        .clock    (clock),
        .reset    (reset),
        .sw_port0 (sw_port0),
        .sw_port1 (sw_port1),
        .ack      (ack),
        .in_port0 (in_port0),
        .in_port1 (in_port1),
        .changed  (changed)
`ifdef INPORT_EDGE_CNT_EN
        ,
        .cnt0     (cnt0),
        .cnt1     (cnt1)
`endif
    );

    always #5 clock = ~clock;

    // Raw value sampled at edge k; anything at or before the last reset edge is lost.
    function automatic logic [4:0] samp(input int bank, input int k);
        if (k <= lastrst) return 5'd0;
        return (bank == 0) ? hist0[k % 64] : hist1[k % 64];
    endfunction

    // Output takes v at edge e when the DB raw samples taken at edges
    // e-DB-2 .. e-3 all equal v and v is not already shown.
    function automatic logic win(input int bank, input int e, input logic [4:0] cur,
                                 output logic [4:0] v);
        v = samp(bank, e - DB - 2);
        for (int k = e - DB - 1; k <= e - 3; k++)
            if (samp(bank, k) !== v) return 1'b0;
        return v !== cur;
    endfunction

    task automatic tick();
        logic u0, u1;
        logic [4:0] v0, v1;
        @(posedge clock);
        edge_n++;
        if (reset) begin
            lastrst = edge_n;
            m_out0 = 5'd0; m_out1 = 5'd0; m_chg = 1'b0;
            m_cnt0 = 8'd0; m_cnt1 = 8'd0;
        end else begin
            hist0[edge_n % 64] = sw_port0;
            hist1[edge_n % 64] = sw_port1;
            u0 = win(0, edge_n, m_out0, v0);
            u1 = win(1, edge_n, m_out1, v1);
            if (u0) begin m_out0 = v0; m_cnt0 = m_cnt0 + 8'd1; end
            if (u1) begin m_out1 = v1; m_cnt1 = m_cnt1 + 8'd1; end
            if (u0 || u1) m_chg = 1'b1;
            else if (ack) m_chg = 1'b0;
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; sw_port0 = 5'h1F; sw_port1 = 5'h1F;
        tick(); tick();
        n_cmp++; if (in_port0 !== 5'h00) begin n_err++; $display("FAIL reset_in0: got %h want 00", in_port0); end
        n_cmp++; if (in_port1 !== 5'h00) begin n_err++; $display("FAIL reset_in1: got %h want 00", in_port1); end
        n_cmp++; if (changed !== 1'b0) begin n_err++; $display("FAIL reset_changed: got %b want 0", changed); end
        sw_port0 = 5'h00; sw_port1 = 5'h00;
        tick();
    endtask

    task automatic test_steady();
        logic [4:0] e0;
        reset = 1'b0; sw_port0 = 5'h15;
        for (int k = 1; k <= 9; k++) begin
            tick();
            e0 = (k >= 7) ? 5'h15 : 5'h00;
            n_cmp++; if (in_port0 !== e0) begin n_err++; $display("FAIL steady_in0 edge %0d: got %h want %h", k, in_port0, e0); end
            n_cmp++; if (changed !== (k >= 7)) begin n_err++; $display("FAIL steady_changed edge %0d: got %b want %b", k, changed, k >= 7); end
        end
    endtask

    task automatic test_glitch();
        ack = 1'b1; tick(); ack = 1'b0;
        sw_port1 = 5'h1F;
        repeat (3) tick();
        sw_port1 = 5'h00;
        for (int k = 0; k < 10; k++) begin
            tick();
            n_cmp++; if (in_port1 !== 5'h00 || changed !== 1'b0) begin n_err++;
                $display("FAIL glitch edge %0d: got in1=%h chg=%b want 00/0", k, in_port1, changed); end
        end
    endtask

    task automatic test_ack();
        sw_port0 = 5'h07;
        repeat (6) tick();
        n_cmp++; if (in_port0 !== 5'h15) begin n_err++; $display("FAIL ack_pre_in0: got %h want 15", in_port0); end
        ack = 1'b1; tick();
        n_cmp++; if (in_port0 !== 5'h07) begin n_err++; $display("FAIL ack_upd_in0: got %h want 07", in_port0); end
        n_cmp++; if (changed !== 1'b1) begin n_err++; $display("FAIL ack_same_edge: got %b want 1", changed); end
        tick(); ack = 1'b0;
        n_cmp++; if (changed !== 1'b0) begin n_err++; $display("FAIL ack_next_edge: got %b want 0", changed); end
    endtask

    task automatic test_both();
        sw_port0 = 5'h1C; sw_port1 = 5'h06;
        repeat (6) tick();
        n_cmp++; if (in_port0 !== 5'h07 || in_port1 !== 5'h00 || changed !== 1'b0) begin n_err++;
            $display("FAIL both_pre: got %h/%h/%b want 07/00/0", in_port0, in_port1, changed); end
        tick();
        n_cmp++; if (in_port0 !== 5'h1C || in_port1 !== 5'h06) begin n_err++;
            $display("FAIL both_upd: got %h/%h want 1c/06", in_port0, in_port1); end
        n_cmp++; if (changed !== 1'b1) begin n_err++; $display("FAIL both_changed: got %b want 1", changed); end
        ack = 1'b1; tick(); ack = 1'b0;
        n_cmp++; if (changed !== 1'b0) begin n_err++; $display("FAIL both_single: got %b want 0", changed); end
    endtask

    task automatic test_reset_mid();
        logic [4:0] e0;
        sw_port0 = 5'h0A;
        repeat (5) tick();
        reset = 1'b1; tick();
        n_cmp++; if (in_port0 !== 5'h00 || in_port1 !== 5'h00 || changed !== 1'b0) begin n_err++;
            $display("FAIL rstmid_clear: got %h/%h/%b want 00/00/0", in_port0, in_port1, changed); end
        reset = 1'b0; sw_port0 = 5'h00; sw_port1 = 5'h00;
        for (int k = 0; k < 10; k++) begin
            tick();
            n_cmp++; if (in_port0 !== 5'h00) begin n_err++; $display("FAIL rstmid_stale edge %0d: got %h want 00", k, in_port0); end
        end
        // Switches already set while in reset: full latency from release.
        sw_port0 = 5'h0A; sw_port1 = 5'h13; reset = 1'b1; tick(); tick();
        reset = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            e0 = (k >= 7) ? 5'h0A : 5'h00;
            n_cmp++; if (in_port0 !== e0) begin n_err++; $display("FAIL release_in0 edge %0d: got %h want %h", k, in_port0, e0); end
        end
    endtask

    task automatic test_random();
        int h0 = 0, h1 = 0;
        for (int i = 0; i < 800; i++) begin
            if (h0 == 0) begin sw_port0 = 5'($urandom_range(0, 31)); h0 = $urandom_range(1, 8); end
            if (h1 == 0) begin sw_port1 = 5'($urandom_range(0, 31)); h1 = $urandom_range(1, 8); end
            h0--; h1--;
            ack = ($urandom_range(0, 3) == 0);
            reset = ($urandom_range(0, 299) == 0);
            tick();
            n_cmp++; if (in_port0 !== m_out0) begin n_err++; $display("FAIL rand_in0 edge %0d: got %h want %h", edge_n, in_port0, m_out0); end
            n_cmp++; if (in_port1 !== m_out1) begin n_err++; $display("FAIL rand_in1 edge %0d: got %h want %h", edge_n, in_port1, m_out1); end
            n_cmp++; if (changed !== m_chg) begin n_err++; $display("FAIL rand_changed edge %0d: got %b want %b", edge_n, changed, m_chg); end
`ifdef INPORT_EDGE_CNT_EN
            n_cmp++; if (cnt0 !== m_cnt0 || cnt1 !== m_cnt1) begin n_err++;
                $display("FAIL rand_cnt edge %0d: got %h/%h want %h/%h", edge_n, cnt0, cnt1, m_cnt0, m_cnt1); end
`endif
        end
        reset = 1'b0; ack = 1'b0;
    endtask

`ifdef INPORT_EDGE_CNT_EN
    task automatic test_wrap();
        sw_port0 = 5'h00; sw_port1 = 5'h00; reset = 1'b1; tick(); tick(); reset = 1'b0;
        for (int i = 0; i < 256; i++) begin
            sw_port0 = (i % 2 == 1) ? 5'h02 : 5'h01;
            repeat (8) tick();
            if (i == 254) begin
                n_cmp++; if (cnt0 !== 8'hFF) begin n_err++; $display("FAIL wrap_ff: got %h want ff", cnt0); end
            end
        end
        n_cmp++; if (cnt0 !== 8'h00) begin n_err++; $display("FAIL wrap_cnt0: got %h want 00", cnt0); end
        n_cmp++; if (cnt1 !== 8'h00) begin n_err++; $display("FAIL wrap_cnt1: got %h want 00", cnt1); end
        n_cmp++; if (in_port0 !== 5'h02) begin n_err++; $display("FAIL wrap_in0: got %h want 02", in_port0); end
    endtask
`endif

    initial begin
        test_reset();
        test_steady();
        test_glitch();
        test_ack();
        test_both();
        test_reset_mid();
        test_random();
`ifdef INPORT_EDGE_CNT_EN
        test_wrap();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
